// File: rtl/im_ahb_slave.sv
// AHB-Lite slave that bridges byte/half/word transfers onto a synchronous single-port
// SRAM, with WAIT_STATES extra data-phase cycles and a two-cycle ERROR response.
`ifndef AHB_TRANS_BITS
`define AHB_TRANS_BITS 2
`endif
`ifndef AHB_SIZE_BITS
`define AHB_SIZE_BITS 3
`endif

module im_ahb_slave #(
  parameter int ADDR_BITS   = 14,
  parameter int WAIT_STATES = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       HSel,
  input  logic [31:0]                HAddress,
  input  logic [`AHB_TRANS_BITS-1:0] HTrans,
  input  logic [`AHB_SIZE_BITS-1:0]  HSize,
  input  logic                       HWrite,
  input  logic [31:0]                HWrite_data,
  input  logic                       HReady_in,
  output logic [31:0]                HRead_data,
  output logic [1:0]                 HResp,
  output logic                       HReady_out,
  output logic                       SRAM_CS,
  output logic                       SRAM_OE,
  output logic [3:0]                 SRAM_WEB,
  output logic [ADDR_BITS-1:0]       SRAM_A,
  output logic [31:0]                SRAM_DI,
  input  logic [31:0]                SRAM_DO
);

  localparam logic [1:0] RESP_OKAY  = 2'd0;
  localparam logic [1:0] RESP_ERROR = 2'd1;
  localparam logic [2:0] CNT_INIT   = 3'(WAIT_STATES - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_ACCESS, ST_DATA, ST_ERR1, ST_ERR2} state_t;

  state_t               r_state;
  logic [2:0]           r_cnt;
  logic [ADDR_BITS-1:0] r_addr;
  logic                 r_write;
  logic [3:0]           r_web;
  logic                 r_rd_first;
  logic [31:0]          r_rbuf;
  logic [31:0]          r_rdata;

  logic        w_sel_xfer;
  logic        w_ready_state;
  logic        w_accept;
  logic        w_err;
  logic        w_final;
  logic        w_to_final;
  logic [3:0]  w_web;
  logic [31:0] w_rd_word;

  assign w_sel_xfer    = HSel && HReady_in &&
                         ((HTrans == `AHB_TRANS_BITS'(2)) || (HTrans == `AHB_TRANS_BITS'(3)));
  assign w_final       = (r_state == ST_DATA) && (r_cnt == 3'd0);
  assign w_ready_state = (r_state == ST_IDLE) || (r_state == ST_ERR2) || w_final;
  assign w_accept      = w_sel_xfer && w_ready_state;
  assign w_to_final    = ((r_state == ST_ACCESS) && (CNT_INIT == 3'd0)) ||
                         ((r_state == ST_DATA) && (r_cnt == 3'd1));

  assign w_err = (HSize > `AHB_SIZE_BITS'(2)) ||
                 ((HSize == `AHB_SIZE_BITS'(1)) && HAddress[0]) ||
                 ((HSize == `AHB_SIZE_BITS'(2)) && (HAddress[1:0] != 2'b00)) ||
                 (|HAddress[31:ADDR_BITS+2]);

  always_comb begin
    // NOTE: default assigned first so every path writes w_web and no latch is inferred.
    w_web = 4'hF;
    case (HSize)
      `AHB_SIZE_BITS'(0): w_web[HAddress[1:0]] = 1'b0;
      `AHB_SIZE_BITS'(1): w_web = HAddress[1] ? 4'h3 : 4'hC;
      `AHB_SIZE_BITS'(2): w_web = 4'h0;
      default:            w_web = 4'hF;
    endcase
  end

  // The SRAM answers one cycle after the ACCESS strobe, so the first DATA cycle
  // takes the word straight from SRAM_DO and later cycles use the buffered copy.
  assign w_rd_word  = r_rd_first ? SRAM_DO : r_rbuf;
  assign HRead_data = (w_final && !r_write) ? w_rd_word : r_rdata;

  always_ff @(posedge clk) begin
    // NOTE: synchronous active-high reset; sequential state uses non-blocking assignments only.
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 3'd0;
      r_addr     <= '0;
      r_write    <= 1'b0;
      r_web      <= 4'hF;
      r_rd_first <= 1'b0;
      r_rbuf     <= 32'd0;
      r_rdata    <= 32'd0;
      HReady_out <= 1'b1;
      HResp      <= RESP_OKAY;
      SRAM_CS    <= 1'b0;
      SRAM_OE    <= 1'b0;
      SRAM_WEB   <= 4'hF;
      SRAM_A     <= '0;
      SRAM_DI    <= 32'd0;
    end else begin
      SRAM_CS    <= 1'b0;
      SRAM_OE    <= 1'b0;
      SRAM_WEB   <= 4'hF;
      r_rd_first <= 1'b0;
      if (r_rd_first) r_rbuf <= SRAM_DO;
      if (w_final && !r_write) r_rdata <= w_rd_word;

      if (w_ready_state) begin
        if (w_accept) begin
          r_addr     <= HAddress[ADDR_BITS+1:2];
          r_write    <= HWrite;
          r_web      <= w_web;
          HReady_out <= 1'b0;
          if (w_err) begin
            r_state <= ST_ERR1;
            HResp   <= RESP_ERROR;
          end else begin
            r_state <= ST_ACCESS;
            HResp   <= RESP_OKAY;
            SRAM_CS <= !HWrite;
            SRAM_OE <= !HWrite;
            SRAM_A  <= HAddress[ADDR_BITS+1:2];
          end
        end else begin
          r_state    <= ST_IDLE;
          HReady_out <= 1'b1;
          HResp      <= RESP_OKAY;
        end
      end else begin
        case (r_state)
          ST_ACCESS: begin
            r_state    <= ST_DATA;
            r_cnt      <= CNT_INIT;
            r_rd_first <= !r_write;
          end
          ST_DATA: r_cnt <= r_cnt - 3'd1;
          ST_ERR1: begin
            r_state    <= ST_ERR2;
            HReady_out <= 1'b1;
          end
          default: r_state <= ST_IDLE;
        endcase
        // Write strobes are launched so they appear only in the final DATA cycle.
        if (w_to_final) begin
          HReady_out <= 1'b1;
          if (r_write) begin
            SRAM_CS  <= 1'b1;
            SRAM_WEB <= r_web;
            SRAM_A   <= r_addr;
            SRAM_DI  <= HWrite_data;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_im_ahb_slave.sv
// Self-checking bench for im_ahb_slave: two instances (WAIT_STATES 1 and 3), each on its
// own SRAM model, checked against a transfer-level reference of the bus rules.
`timescale 1ns/1ps

module tb_im_ahb_slave;

  localparam int AB    = 14;
  localparam int DEPTH = 1 << AB;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hwrite;
  logic [31:0] hwdata;
  logic        gate;
  logic        do_fill;
  logic        use_seq;
  int          cur;

  logic          sel   [2];
  logic          hrin  [2];
  logic [31:0]   rdata [2];
  logic [1:0]    resp  [2];
  logic          rdy   [2];
  logic          cs    [2];
  logic          oe    [2];
  logic [3:0]    web   [2];
  logic [AB-1:0] sa    [2];
  logic [31:0]   di    [2];
  logic [31:0]   sdo   [2];

  logic [31:0] mem     [2][DEPTH];
  logic [31:0] ref_mem [2][DEPTH];

  txn_t tq[$];
  int   total = 0;
  int   bad   = 0;

  int          last_cycles;
  int          last_cs;
  logic [31:0] last_rdata;
  logic [3:0]  last_web;
  logic [AB-1:0] last_a;

  always #5 clk = ~clk;

  assign sel[0]  = hsel && (cur == 0);
  assign sel[1]  = hsel && (cur == 1);
  assign hrin[0] = rdy[0] & gate;
  assign hrin[1] = rdy[1] & gate;

  im_ahb_slave #(.ADDR_BITS(AB), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst(rst), .HSel(sel[0]), .HAddress(haddr), .HTrans(htrans), .HSize(hsize),
    .HWrite(hwrite), .HWrite_data(hwdata), .HReady_in(hrin[0]), .HRead_data(rdata[0]),
    .HResp(resp[0]), .HReady_out(rdy[0]), .SRAM_CS(cs[0]), .SRAM_OE(oe[0]), .SRAM_WEB(web[0]),
    .SRAM_A(sa[0]), .SRAM_DI(di[0]), .SRAM_DO(sdo[0]));

  im_ahb_slave #(.ADDR_BITS(AB), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst), .HSel(sel[1]), .HAddress(haddr), .HTrans(htrans), .HSize(hsize),
    .HWrite(hwrite), .HWrite_data(hwdata), .HReady_in(hrin[1]), .HRead_data(rdata[1]),
    .HResp(resp[1]), .HReady_out(rdy[1]), .SRAM_CS(cs[1]), .SRAM_OE(oe[1]), .SRAM_WEB(web[1]),
    .SRAM_A(sa[1]), .SRAM_DI(di[1]), .SRAM_DO(sdo[1]));

  function automatic logic [31:0] fill_word(input int k, input int i);
    return (32'(i) * 32'h9E37_79B1) ^ ((k == 1) ? 32'hFFFF_0000 : 32'h0);
  endfunction

  // Synchronous SRAM: read data appears the cycle after a CS+OE strobe.
  always @(posedge clk) begin
    if (do_fill) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < DEPTH; i++) mem[k][i] <= fill_word(k, i);
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (cs[k] === 1'b1) begin
          if (oe[k]) sdo[k] <= mem[k][sa[k]];
          for (int b = 0; b < 4; b++)
            if (!web[k][b]) mem[k][sa[k]][b*8 +: 8] <= di[k][b*8 +: 8];
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic int ws_cur();
    return (cur == 1) ? 3 : 1;
  endfunction

  function automatic logic exp_err(input logic [31:0] a, input logic [2:0] s);
    int unsigned nbytes;
    if (s > 3'd2) return 1'b1;
    nbytes = 1 << s;
    if ((a % nbytes) != 0) return 1'b1;
    if (a >= (32'd4 << AB)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] exp_web(input logic [31:0] a, input logic [2:0] s);
    int   lane;
    int   nbytes;
    logic [3:0] m;
    lane   = int'(a[1:0]);
    nbytes = 1 << s;
    m      = 4'h0;
    for (int b = 0; b < 4; b++) if (b >= lane && b < lane + nbytes) m[b] = 1'b1;
    return ~m;
  endfunction

  function automatic txn_t mk(input logic wr, input logic [31:0] a, input logic [2:0] s,
                              input logic [31:0] wd);
    txn_t t;
    t.wr = wr; t.addr = a; t.size = s; t.wdata = wd;
    return t;
  endfunction

  // ---------------- bus driver ----------------
  task automatic drive_addr(input txn_t t);
    hsel   = 1'b1;
    htrans = (use_seq && $urandom_range(0, 1) == 1) ? 2'd3 : 2'd2;
    haddr  = t.addr;
    hwrite = t.wr;
    hsize  = t.size;
  endtask

  task automatic drive_idle();
    hsel   = 1'b1;
    htrans = 2'd0;
    haddr  = $urandom;
    hwrite = 1'b0;
    hsize  = 3'd2;
  endtask

  // Issues every transfer in tq back-to-back, next address overlapping the current data phase.
  task automatic run_queue();
    txn_t t;
    int   n, cycles, cs_cnt, cs_at, e_len;
    logic e_err, resp_ok, done, s_oe;
    logic [3:0]    s_web;
    logic [AB-1:0] s_a;
    logic [31:0]   s_di, s_rd, e_rd;
    logic [3:0]    e_web;
    n = tq.size();
    @(negedge clk);
    drive_addr(tq[0]);
    for (int i = 0; i < n; i++) begin
      t     = tq[i];
      e_err = exp_err(t.addr, t.size);
      e_len = e_err ? 2 : ws_cur() + 1;
      e_web = exp_web(t.addr, t.size);
      e_rd  = ref_mem[cur][t.addr[AB+1:2]];
      cycles = 0; cs_cnt = 0; cs_at = 0; resp_ok = 1'b1; done = 1'b0;
      s_oe = 1'b0; s_web = 4'hF; s_a = '0; s_di = 32'd0; s_rd = 32'd0;
      @(posedge clk);
      while (!done) begin
        @(negedge clk);
        cycles++;
        if (cycles == 1) begin
          hwdata = t.wdata;
          if (i + 1 < n) drive_addr(tq[i+1]);
          else drive_idle();
        end
        if (resp[cur] !== (e_err ? 2'd1 : 2'd0)) resp_ok = 1'b0;
        if (cs[cur] !== 1'b0) begin
          cs_cnt++; cs_at = cycles;
          s_oe = oe[cur]; s_web = web[cur]; s_a = sa[cur]; s_di = di[cur];
        end
        s_rd = rdata[cur];
        done = (rdy[cur] === 1'b1) || (cycles >= 20);
      end
      last_cycles = cycles; last_cs = cs_cnt; last_rdata = s_rd; last_web = s_web; last_a = s_a;

      total++;
      if (cycles != e_len) begin
        bad++;
        $display("FAIL len ws%0d addr=%h wr=%0d: got %0d cycles, want %0d", ws_cur(), t.addr, t.wr, cycles, e_len);
      end
      total++;
      if (!resp_ok) begin
        bad++;
        $display("FAIL resp ws%0d addr=%h: HResp not %0d throughout data phase", ws_cur(), t.addr, e_err);
      end
      total++;
      if (cs_cnt != (e_err ? 0 : 1)) begin
        bad++;
        $display("FAIL cs_count ws%0d addr=%h: got %0d CS cycles, want %0d", ws_cur(), t.addr, cs_cnt, e_err ? 0 : 1);
      end
      if (!e_err && t.wr) begin
        total++;
        if (cs_at != cycles || s_oe !== 1'b0 || s_web !== e_web || s_a !== t.addr[AB+1:2] || s_di !== t.wdata) begin
          bad++;
          $display("FAIL write_strobe ws%0d addr=%h: at=%0d oe=%b web=%h a=%h di=%h, want at=%0d oe=0 web=%h a=%h di=%h",
                   ws_cur(), t.addr, cs_at, s_oe, s_web, s_a, s_di, cycles, e_web, t.addr[AB+1:2], t.wdata);
        end
        for (int b = 0; b < 4; b++)
          if (!e_web[b]) ref_mem[cur][t.addr[AB+1:2]][b*8 +: 8] = t.wdata[b*8 +: 8];
      end
      if (!e_err && !t.wr) begin
        total++;
        if (cs_at != 1 || s_oe !== 1'b1 || s_web !== 4'hF || s_a !== t.addr[AB+1:2]) begin
          bad++;
          $display("FAIL read_strobe ws%0d addr=%h: at=%0d oe=%b web=%h a=%h, want at=1 oe=1 web=f a=%h",
                   ws_cur(), t.addr, cs_at, s_oe, s_web, s_a, t.addr[AB+1:2]);
        end
        total++;
        if (s_rd !== e_rd) begin
          bad++;
          $display("FAIL read_data ws%0d addr=%h: got %h, want %h", ws_cur(), t.addr, s_rd, e_rd);
        end
      end
    end
    tq.delete();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({rdy[k], resp[k], rdata[k], cs[k], oe[k], web[k], sa[k], di[k]} !==
          {1'b1, 2'd0, 32'd0, 1'b0, 1'b0, 4'hF, {AB{1'b0}}, 32'd0}) begin
        bad++;
        $display("FAIL reset_state inst%0d: rdy=%b resp=%0d rd=%h cs=%b oe=%b web=%h a=%h di=%h, want 1 0 0 0 0 f 0 0",
                 k, rdy[k], resp[k], rdata[k], cs[k], oe[k], web[k], sa[k], di[k]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_idle_busy();
    logic [2:0] pat [3];
    cur = 0;
    pat[0] = 3'b100; pat[1] = 3'b101; pat[2] = 3'b010;  // {hsel, htrans}
    for (int p = 0; p < 3; p++) begin
      @(negedge clk);
      hsel = pat[p][2]; htrans = pat[p][1:0]; haddr = 32'h40; hsize = 3'd2; hwrite = 1'b0;
      @(negedge clk);
      total++;
      if (rdy[0] !== 1'b1 || resp[0] !== 2'd0 || cs[0] !== 1'b0) begin
        bad++;
        $display("FAIL idle_okay sel=%b trans=%0d: rdy=%b resp=%0d cs=%b, want 1 0 0", pat[p][2], pat[p][1:0], rdy[0], resp[0], cs[0]);
      end
    end
    drive_idle();
  endtask

  task automatic test_ready_in_low();
    cur = 0;
    @(negedge clk);
    gate = 1'b0; hsel = 1'b1; htrans = 2'd2; haddr = 32'h44; hsize = 3'd2; hwrite = 1'b0;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (rdy[0] !== 1'b1 || cs[0] !== 1'b0 || resp[0] !== 2'd0) begin
        bad++;
        $display("FAIL ready_in_low: rdy=%b cs=%b resp=%0d, want 1 0 0", rdy[0], cs[0], resp[0]);
      end
    end
    drive_idle();
    gate = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word_read();
    cur = 0;
    tq.push_back(mk(1'b1, 32'h40, 3'd2, 32'hDEAD_BEEF));
    tq.push_back(mk(1'b0, 32'h40, 3'd2, 32'h0));
    run_queue();
    total++;
    if (last_rdata !== 32'hDEAD_BEEF || last_cycles != 2) begin
      bad++;
      $display("FAIL word_read: data=%h cycles=%0d, want deadbeef 2", last_rdata, last_cycles);
    end
  endtask

  task automatic test_byte_write();
    cur = 0;
    tq.push_back(mk(1'b1, 32'h43, 3'd0, 32'hA500_0000));
    run_queue();
    total++;
    if (last_web !== 4'h7 || last_a !== AB'(16) || last_cs != 1) begin
      bad++;
      $display("FAIL byte_write: web=%h a=%h cs_cycles=%0d, want 7 10 1", last_web, last_a, last_cs);
    end
    tq.push_back(mk(1'b0, 32'h40, 3'd2, 32'h0));
    run_queue();
    total++;
    if (last_rdata !== 32'hA5AD_BEEF) begin
      bad++;
      $display("FAIL byte_readback: got %h, want a5adbeef", last_rdata);
    end
  endtask

  task automatic test_errors();
    cur = 0;
    tq.push_back(mk(1'b0, 32'h42, 3'd2, 32'h0));
    tq.push_back(mk(1'b0, 32'h0001_0000, 3'd2, 32'h0));
    tq.push_back(mk(1'b1, 32'h41, 3'd1, 32'h1234_5678));
    tq.push_back(mk(1'b0, 32'h40, 3'd3, 32'h0));
    run_queue();
  endtask

  task automatic test_back_to_back();
    cur = 1;
    tq.push_back(mk(1'b1, 32'h0, 3'd2, 32'h0BAD_F00D));
    tq.push_back(mk(1'b1, 32'h4, 3'd2, 32'hCAFE_1234));
    run_queue();
    tq.push_back(mk(1'b0, 32'h0, 3'd2, 32'h0));
    tq.push_back(mk(1'b0, 32'h4, 3'd2, 32'h0));
    run_queue();
    total++;
    if (last_rdata !== 32'hCAFE_1234 || last_cycles != 4) begin
      bad++;
      $display("FAIL b2b_second: data=%h cycles=%0d, want cafe1234 4", last_rdata, last_cycles);
    end
  endtask

  task automatic test_reset_mid_write();
    cur = 1;
    @(negedge clk);
    drive_addr(mk(1'b1, 32'h80, 3'd2, 32'h1122_3344));
    @(posedge clk);
    @(negedge clk);
    hwdata = 32'h1122_3344;
    drive_idle();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (rdy[1] !== 1'b1 || resp[1] !== 2'd0 || web[1] !== 4'hF || cs[1] !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_write: rdy=%b resp=%0d web=%h cs=%b, want 1 0 f 0", rdy[1], resp[1], web[1], cs[1]);
    end
    repeat (3) begin
      @(negedge clk);
      total++;
      if (web[1] !== 4'hF || cs[1] !== 1'b0) begin
        bad++;
        $display("FAIL abandoned_write: web=%h cs=%b, want f 0", web[1], cs[1]);
      end
    end
    tq.push_back(mk(1'b0, 32'h80, 3'd2, 32'h0));
    run_queue();
  endtask

  function automatic txn_t rand_txn();
    logic [2:0]  s;
    logic [31:0] a;
    s = ($urandom_range(0, 19) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
    a = {24'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
    if (s <= 3'd2 && $urandom_range(0, 3) != 0) a[1:0] = a[1:0] & ~2'((1 << s) - 1);
    if ($urandom_range(0, 15) == 0) a = a | (32'd1 << $urandom_range(AB + 2, 31));
    return mk(1'($urandom_range(0, 1)), a, s, $urandom);
  endfunction

  task automatic test_random();
    int len;
    use_seq = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cur = k;
      repeat (10) begin
        len = $urandom_range(1, 5);
        repeat (len) tq.push_back(rand_txn());
        run_queue();
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    use_seq = 1'b0;
  endtask

  initial begin
    rst = 1'b1; hsel = 1'b0; htrans = 2'd0; haddr = 32'd0; hsize = 3'd2; hwrite = 1'b0;
    hwdata = 32'd0; gate = 1'b1; do_fill = 1'b1; use_seq = 1'b0; cur = 0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < DEPTH; i++) ref_mem[k][i] = fill_word(k, i);
    @(posedge clk);
    @(negedge clk);
    do_fill = 1'b0;

    test_reset();
    test_idle_busy();
    test_ready_in_low();
    test_word_read();
    test_byte_write();
    test_errors();
    test_back_to_back();
    test_reset_mid_write();
    test_random();

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
